meas_sequencer: RTL and testbench
=================================

// Module: meas_sequencer
// PURPOSE
//  Top-level sequencer for the frequency meter datapath. Runs repeated gate windows
//  and counts input edges in each one. Each count is written into a 4-entry sample RAM.
//  After every 4th sample, it starts the averaging engine and waits for its done.
//  It then publishes the averaged frequency with a one-cycle valid strobe.
// PARAMETERS
//  GATE_CYCLES  100_000_000  clk cycles per gate window (1 s @ 100 MHz); must be >= 2
//  CW           25           count/sample/average width
//  AVG_TIMEOUT  64           max cycles in AVERAGE waiting for avg_done before error
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  reset           in   1   synchronous, active-high reset
//  enable          in   1   1 = run measurement cycles, 0 = stop after current average
//  sig_edge        in   1   1-cycle pulse per input rising edge (pre-synchronised)
//  sample_wr_en    out  1   sample RAM write strobe
//  sample_wr_addr  out  2   sample RAM write address
//  sample_wr_data  out  CW  edge count for the finished gate window
//  avg_active      out  1   level; keeps averaging engine running while high
//  avg_done        in   1   averaging engine finished; avg_in valid same cycle
//  avg_in          in   CW  averaged count from the engine
//  freq_out        out  CW  last published average (holds between updates)
//  freq_valid      out  1   1-cycle strobe when freq_out updates
//  busy            out  1   high in any state other than IDLE
//  overflow        out  1   sticky: some sample in the current block saturated
//  avg_error       out  1   sticky: avg_done not seen within AVG_TIMEOUT
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, state = IDLE, wr_ptr = 0, gate_cnt = 0, edge_cnt = 0.
//   - Reset mid-operation drops avg_active on the next edge; no RAM write occurs.
//  States:
//   - IDLE: waits for enable=1, then goes to GATE and clears gate_cnt/edge_cnt.
//   - GATE: gate_cnt increments each cycle.
//     - edge_cnt increments on each sig_edge, including the last gate cycle.
//     - edge_cnt saturates at 2^CW-1; an edge arriving at saturation sets overflow.
//     - When gate_cnt == GATE_CYCLES-1, goes to STORE.
//     - If enable=0 during GATE: aborts to IDLE, discards the partial count, and
//       resets wr_ptr to 0. Nothing is written.
//   - STORE (1 cycle):
//     - Drives sample_wr_en=1, sample_wr_addr=wr_ptr, sample_wr_data=edge_cnt.
//     - Then wr_ptr <= wr_ptr+1, wrapping mod 4.
//     - If wr_ptr was 3, goes to AVERAGE; otherwise goes to GATE with counters cleared.
//     - Edges during STORE are not counted (dead time: 1 cycle per window).
//   - AVERAGE:
//     - avg_active=1 from the first AVERAGE cycle through the cycle avg_done is seen.
//     - On avg_done=1: registers freq_out <= avg_in, then goes to PUBLISH.
//     - If AVG_TIMEOUT cycles pass without avg_done: sets avg_error=1, leaves freq_out
//       unchanged, goes to PUBLISH, and suppresses freq_valid.
//     - avg_done while not in AVERAGE is ignored.
//   - PUBLISH (1 cycle):
//     - Drives avg_active=0 and freq_valid=1 (unless timeout).
//     - Clears overflow unless it was set in this block; overflow persists until the
//       next PUBLISH.
//     - Goes to GATE if enable=1, else IDLE.
//  Cycle rules:
//   - Latency from the last gate cycle to the first avg_active is 2 clks.
//   - Latency from avg_done to freq_valid is 1 clk.
//   - A publish occurs every 4 windows; the sample RAM is never written during AVERAGE.
//   - avg_error is sticky until reset.
// TESTING  (GATE_CYCLES=10 for sim)
//  1. Reset, enable=1, sig_edge every 2 clks, engine model returns mean after 6 clks
//     -> 4 writes at addr 0,1,2,3, each data=5; then avg_active rises 2 clks later;
//     freq_out=5 with one freq_valid pulse.
//  2. Edge counts 1,2,3,6 over 4 windows -> writes 1,2,3,6 at addr 0..3;
//     freq_out=avg_in (3); next block writes again starting at addr 0.
//  3. enable=0 midway through window 3 -> no 3rd write, IDLE next cycle;
//     re-enable -> next write goes to addr 0.
//  4. CW=3, sig_edge held high for a full window -> sample_wr_data=7, overflow=1
//     through PUBLISH; the next clean block clears overflow.
//  5. Engine never asserts avg_done -> avg_error=1 after 64 cycles, no freq_valid,
//     freq_out unchanged, sequencing continues.
//  6. reset pulse while avg_active=1 -> avg_active=0, busy=0, all outputs 0 on the
//     next clk.

Source files
------------

// File: rtl/meas_sequencer.sv
// Frequency meter sequencer: counts input edges over repeated gate windows, stores
// four samples per block, hands the block to the averaging engine and publishes the result.
module meas_sequencer #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CW          = 25,
    parameter int AVG_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sig_edge,
    output logic          sample_wr_en,
    output logic [1:0]    sample_wr_addr,
    output logic [CW-1:0] sample_wr_data,
    output logic          avg_active,
    input  logic          avg_done,
    input  logic [CW-1:0] avg_in,
    output logic [CW-1:0] freq_out,
    output logic          freq_valid,
    output logic          busy,
    output logic          overflow,
    output logic          avg_error
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int TW = $clog2(AVG_TIMEOUT + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(AVG_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GATE    = 3'd1,
        STORE   = 3'd2,
        AVERAGE = 3'd3,
        PUBLISH = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [GW-1:0] gate_cnt_r, gate_cnt_s;
    logic [CW-1:0] edge_cnt_r, edge_cnt_s;
    logic [1:0]    wr_ptr_r, wr_ptr_s;
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
    logic          ovf_block_r, ovf_block_s;

    logic          wr_en_s;
    logic [1:0]    wr_addr_s;
    logic [CW-1:0] wr_data_s;
    logic          avg_active_s;
    logic [CW-1:0] freq_out_s;
    logic          freq_valid_s;
    logic          busy_s;
    logic          overflow_s;
    logic          avg_error_s;

    // Next-state, counter and output decode; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s      = state_r;
        gate_cnt_s   = gate_cnt_r;
        edge_cnt_s   = edge_cnt_r;
        wr_ptr_s     = wr_ptr_r;
        tmo_cnt_s    = tmo_cnt_r;
        ovf_block_s  = ovf_block_r;
        wr_en_s      = 1'b0;
        wr_addr_s    = 2'd0;
        wr_data_s    = {CW{1'b0}};
        avg_active_s = 1'b0;
        freq_out_s   = freq_out;
        freq_valid_s = 1'b0;
        overflow_s   = overflow;
        avg_error_s  = avg_error;

        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s    = GATE;
                    gate_cnt_s = {GW{1'b0}};
                    edge_cnt_s = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end

            GATE: begin
                if (!enable) begin
                    // Abort discards the partial window and restarts the block at slot 0.
                    state_s    = IDLE;
                    gate_cnt_s = {GW{1'b0}};
                    edge_cnt_s = {CW{1'b0}};
                    wr_ptr_s   = 2'd0;
                end else begin
                    gate_cnt_s = gate_cnt_r + GW'(1);
                    if (sig_edge && (edge_cnt_r == CNT_MAX)) begin
                        overflow_s  = 1'b1;
                        ovf_block_s = 1'b1;
                    end else if (sig_edge) begin
                        edge_cnt_s = edge_cnt_r + CW'(1);
                    end else begin
                        edge_cnt_s = edge_cnt_r;
                    end
                    if (gate_cnt_r == GATE_LAST) begin
                        state_s   = STORE;
                        wr_en_s   = 1'b1;
                        wr_addr_s = wr_ptr_r;
                        wr_data_s = edge_cnt_s;
                    end else begin
                        state_s = GATE;
                    end
                end
            end

            STORE: begin
                wr_ptr_s = wr_ptr_r + 2'd1;
                if (wr_ptr_r == 2'd3) begin
                    state_s      = AVERAGE;
                    tmo_cnt_s    = {TW{1'b0}};
                    avg_active_s = 1'b1;
                end else begin
                    state_s    = GATE;
                    gate_cnt_s = {GW{1'b0}};
                    edge_cnt_s = {CW{1'b0}};
                end
            end

            AVERAGE: begin
                if (avg_done) begin
                    state_s      = PUBLISH;
                    freq_out_s   = avg_in;
                    freq_valid_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_s     = PUBLISH;
                    avg_error_s = 1'b1;
                end else begin
                    state_s      = AVERAGE;
                    tmo_cnt_s    = tmo_cnt_r + TW'(1);
                    avg_active_s = 1'b1;
                end
            end

            PUBLISH: begin
                // An overflowed block keeps the flag up through the following block.
                overflow_s  = ovf_block_r;
                ovf_block_s = 1'b0;
                if (enable) begin
                    state_s    = GATE;
                    gate_cnt_s = {GW{1'b0}};
                    edge_cnt_s = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            gate_cnt_r     <= {GW{1'b0}};
            edge_cnt_r     <= {CW{1'b0}};
            wr_ptr_r       <= 2'd0;
            tmo_cnt_r      <= {TW{1'b0}};
            ovf_block_r    <= 1'b0;
            sample_wr_en   <= 1'b0;
            sample_wr_addr <= 2'd0;
            sample_wr_data <= {CW{1'b0}};
            avg_active     <= 1'b0;
            freq_out       <= {CW{1'b0}};
            freq_valid     <= 1'b0;
            busy           <= 1'b0;
            overflow       <= 1'b0;
            avg_error      <= 1'b0;
        end else begin
            state_r        <= state_s;
            gate_cnt_r     <= gate_cnt_s;
            edge_cnt_r     <= edge_cnt_s;
            wr_ptr_r       <= wr_ptr_s;
            tmo_cnt_r      <= tmo_cnt_s;
            ovf_block_r    <= ovf_block_s;
            sample_wr_en   <= wr_en_s;
            sample_wr_addr <= wr_addr_s;
            sample_wr_data <= wr_data_s;
            avg_active     <= avg_active_s;
            freq_out       <= freq_out_s;
            freq_valid     <= freq_valid_s;
            busy           <= busy_s;
            overflow       <= overflow_s;
            avg_error      <= avg_error_s;
        end
    end

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer: a table of four-window blocks plus hand-written
// abort, ignored-done, timeout and mid-average reset sequences.
module tb_meas_sequencer;

    localparam int CW   = 3;
    localparam int GC   = 10;
    localparam int TMO  = 64;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          sig_edge;
    logic          sample_wr_en;
    logic [1:0]    sample_wr_addr;
    logic [CW-1:0] sample_wr_data;
    logic          avg_active;
    logic          avg_done;
    logic [CW-1:0] avg_in;
    logic [CW-1:0] freq_out;
    logic          freq_valid;
    logic          busy;
    logic          overflow;
    logic          avg_error;

    meas_sequencer #(.GATE_CYCLES(GC), .CW(CW), .AVG_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sig_edge(sig_edge),
        .sample_wr_en(sample_wr_en), .sample_wr_addr(sample_wr_addr),
        .sample_wr_data(sample_wr_data), .avg_active(avg_active),
        .avg_done(avg_done), .avg_in(avg_in), .freq_out(freq_out),
        .freq_valid(freq_valid), .busy(busy), .overflow(overflow),
        .avg_error(avg_error)
    );

    // One block = four windows; e* are edges per window, ovf_* = -1 means not checked.
    typedef struct {
        int e0;
        int e1;
        int e2;
        int e3;
        int ovf_pub;
        int ovf_post;
    } blk_t;

    blk_t blks [4];

    int tests;
    int fails;
    int wr_seen;
    int fv_seen;
    int wr_in_avg;
    int exp_wr;
    int exp_fv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write and publish strobes independently of the directed checks.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (sample_wr_en === 1'b1) wr_seen++;
            if (freq_valid === 1'b1) fv_seen++;
            if (sample_wr_en === 1'b1 && avg_active === 1'b1) wr_in_avg++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampc(input int n);
        return (n > MAXC) ? MAXC : n;
    endfunction

    // Drives one gate window with n edges at its start, checks the store cycle, steps past it.
    task automatic run_window(input int n, input int addr);
        for (int i = 0; i < GC; i++) begin
            sig_edge = (i < n);
            tick();
        end
        sig_edge = 1'b0;
        check("wr_en", sample_wr_en, 1);
        check("wr_addr", sample_wr_addr, addr);
        check("wr_data", sample_wr_data, clampc(n));
        check("avg_active_in_store", avg_active, 0);
        exp_wr++;
        tick();
    endtask

    initial begin
        int ev [4];
        int sum;
        int mean;
        int n;

        tests = 0; fails = 0; wr_seen = 0; fv_seen = 0; wr_in_avg = 0;
        exp_wr = 0; exp_fv = 0;

        blks[0] = '{e0: 5,  e1: 5, e2: 5, e3: 5, ovf_pub: 0,  ovf_post: 0};
        blks[1] = '{e0: 1,  e1: 2, e2: 3, e3: 6, ovf_pub: 0,  ovf_post: 0};
        blks[2] = '{e0: 10, e1: 0, e2: 0, e3: 0, ovf_pub: 1,  ovf_post: -1};
        blks[3] = '{e0: 7,  e1: 7, e2: 7, e3: 7, ovf_pub: -1, ovf_post: 0};

        reset = 1'b1; enable = 1'b0; sig_edge = 1'b0; avg_done = 1'b0; avg_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_wr_en", sample_wr_en, 0);
        check("rst_avg_active", avg_active, 0);
        check("rst_freq_out", freq_out, 0);
        check("rst_freq_valid", freq_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_avg_error", avg_error, 0);

        enable = 1'b1;
        tick();
        check("busy_after_enable", busy, 1);

        // Table-driven blocks with an engine model answering the mean after 6 cycles.
        for (int b = 0; b < 4; b++) begin
            ev[0] = blks[b].e0; ev[1] = blks[b].e1; ev[2] = blks[b].e2; ev[3] = blks[b].e3;
            sum = 0;
            for (int w = 0; w < 4; w++) begin
                run_window(ev[w], w);
                sum += clampc(ev[w]);
            end
            check("avg_latency", avg_active, 1);
            mean = sum / 4;
            repeat (5) tick();
            check("avg_hold", avg_active, 1);
            avg_done = 1'b1;
            avg_in   = CW'(mean);
            tick();
            check("publish_valid", freq_valid, 1);
            check("publish_freq", freq_out, mean);
            check("publish_avg_drop", avg_active, 0);
            check("publish_busy", busy, 1);
            if (blks[b].ovf_pub >= 0) check("publish_overflow", overflow, blks[b].ovf_pub);
            exp_fv++;
            avg_done = 1'b0;
            avg_in   = '0;
            tick();
            check("valid_one_cycle", freq_valid, 0);
            if (blks[b].ovf_post >= 0) check("post_overflow", overflow, blks[b].ovf_post);
        end
        check("no_error_yet", avg_error, 0);

        // Abort mid window 3; a stray avg_done outside AVERAGE must be ignored.
        run_window(2, 0);
        run_window(2, 1);
        for (int i = 0; i < 5; i++) begin
            sig_edge = i[0];
            if (i == 2) begin
                avg_done = 1'b1;
                avg_in   = 3'd6;
            end
            tick();
            if (i == 2) begin
                check("stray_done_valid", freq_valid, 0);
                check("stray_done_freq", freq_out, 7);
                avg_done = 1'b0;
                avg_in   = '0;
            end
        end
        sig_edge = 1'b0;
        enable   = 1'b0;
        tick();
        check("abort_idle", busy, 0);
        check("abort_no_write", sample_wr_en, 0);
        repeat (3) tick();
        enable = 1'b1;
        tick();
        check("reenable_busy", busy, 1);
        run_window(3, 0);
        run_window(1, 1);
        run_window(0, 2);
        run_window(4, 3);

        // Engine never answers: expect exactly TMO cycles of avg_active, then error.
        n = 0;
        while (avg_active === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check("timeout_cycles", n, TMO);
        check("timeout_error", avg_error, 1);
        check("timeout_no_valid", freq_valid, 0);
        check("timeout_freq_hold", freq_out, 7);
        tick();
        run_window(2, 0);
        check("error_sticky", avg_error, 1);
        run_window(1, 1);
        run_window(1, 2);
        run_window(1, 3);
        repeat (2) tick();
        check("avg_before_reset", avg_active, 1);

        // Reset while averaging clears everything on the next edge.
        reset = 1'b1;
        tick();
        check("mid_rst_avg_active", avg_active, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_en", sample_wr_en, 0);
        check("mid_rst_freq_out", freq_out, 0);
        check("mid_rst_freq_valid", freq_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_avg_error", avg_error, 0);
        reset = 1'b0;
        tick();

        check("write_count", wr_seen, exp_wr);
        check("publish_count", fv_seen, exp_fv);
        check("write_during_avg", wr_in_avg, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
